// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types and default timing constants for the step ramp generator
//
// Purpose: ramp FSM state type and the default step-timing constants used as
//          parameter defaults by step_ramp_gen and step_timer.
// Ports:   none (package).
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } ramp_state_t;

  localparam int DEF_PERIOD_W   = 24;
  localparam int DEF_MAX_PERIOD = 270000;  // 100 Hz at 27 MHz
  localparam int DEF_MIN_PERIOD = 2700;    // 10 kHz at 27 MHz
  localparam int DEF_ACCEL_STEP = 64;
  localparam int DEF_PULSE_W    = 16;
  localparam int DEF_STEPS_W    = 24;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - step period countdown with pulse-width stretch
//
// Purpose: counts down the current step period; when it expires, raises
//          pulse for PULSE_W cycles and strobes tick on the cycle before
//          the rising edge, reloading with the period presented at that moment.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         restart the countdown with period (move accept)
//   enable       countdown runs only while high
//   period       period to load on load or tick (already the updated value)
//   tick         1-cycle strobe; pulse rises on the following clock edge
//   pulse        step pulse, PULSE_W cycles high
module step_timer
  import motor_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int PULSE_W  = DEF_PULSE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick,
  output logic                pulse
);

  localparam int HOLD_W = $clog2(PULSE_W + 1);

  logic [PERIOD_W-1:0] cnt;
  logic [HOLD_W-1:0]   hold;

  // cnt holds cycles remaining until the rising edge, so a loaded value of
  // P places the edge exactly P clocks after the load edge.
  assign tick  = enable && (cnt == PERIOD_W'(1));
  assign pulse = (hold != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hold <= '0;
    end else begin
      if (load || tick) begin
        cnt <= period;
      end else if (enable && cnt != '0) begin
        cnt <= cnt - PERIOD_W'(1);
      end

      if (tick) begin
        hold <= HOLD_W'(PULSE_W);
      end else if (hold != '0) begin
        hold <= hold - HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_ramp_gen.sv
// rtl/step_ramp_gen.sv - trapezoidal step-pulse generator (accel / cruise / decel)
//
// Purpose: accepts a move (step count + direction) and emits rotate_pulse with
//          an accelerating, cruising and decelerating step period so the motor
//          never starts or stops at full rate.
// Optional feature macro: STEP_POSITION_EN (adds pos_clr input, position output).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   cmd_valid      move command valid
//   cmd_ready      high only in IDLE; accept on cmd_valid && cmd_ready
//   cmd_steps      number of pulses to emit
//   cmd_dir        1 = forward, 0 = reverse
//   abort          level; forces a controlled deceleration
//   rotate_pulse   step pulse, PULSE_W cycles high
//   direction      direction latched for the whole move
//   busy           high from accept until done
//   done           1-cycle completion strobe
//   steps_left     pulses still to emit
//   pos_clr        (STEP_POSITION_EN) clear position, beats a same-cycle step
//   position       (STEP_POSITION_EN) signed pulse position, wraps
module step_ramp_gen
  import motor_pkg::*;
#(
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int ACCEL_STEP = DEF_ACCEL_STEP,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int STEPS_W    = DEF_STEPS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               cmd_dir,
  input  logic               abort,
  output logic               rotate_pulse,
  output logic               direction,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps_left
`ifdef STEP_POSITION_EN
  ,
  input  logic               pos_clr,
  output logic signed [31:0] position
`endif
);

  localparam logic [PERIOD_W-1:0] P_MAX  = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] P_MIN  = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] P_STEP = PERIOD_W'(ACCEL_STEP);

  ramp_state_t         state, state_nxt;
  logic [PERIOD_W-1:0] period, period_nxt, period_up, period_dn;
  logic [STEPS_W-1:0]  ramp_cnt, ramp_nxt, ramp_cand;
  logic [STEPS_W-1:0]  left_nxt, left_dec;
  logic                accept, finishing, timer_en, tick;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Last pulse emitted (or none requested) and its high time is over.
  assign finishing = (state != IDLE) && (steps_left == '0) && !rotate_pulse;
  assign done      = finishing;
  assign busy      = (state != IDLE) && !finishing;
  assign timer_en  = (state != IDLE) && (steps_left != '0);

  // Saturating period math: compare before adding/subtracting so nothing wraps.
  assign period_up = (period > P_MAX - P_STEP) ? P_MAX : period + P_STEP;
  assign period_dn = (period < P_MIN + P_STEP) ? P_MIN : period - P_STEP;
  assign left_dec  = steps_left - STEPS_W'(1);

  step_timer #(
    .PERIOD_W(PERIOD_W),
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .enable(timer_en),
    .period(period_nxt),
    .tick  (tick),
    .pulse (rotate_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      period     <= P_MAX;
      ramp_cnt   <= '0;
      steps_left <= '0;
      direction  <= 1'b0;
    end else begin
      state      <= state_nxt;
      period     <= period_nxt;
      ramp_cnt   <= ramp_nxt;
      steps_left <= left_nxt;
      if (accept) begin
        direction <= cmd_dir;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    period_nxt = period;
    ramp_nxt   = ramp_cnt;
    left_nxt   = steps_left;
    ramp_cand  = ramp_cnt;

    if (accept) begin
      state_nxt  = ACCEL;
      period_nxt = P_MAX;
      ramp_nxt   = '0;
      left_nxt   = cmd_steps;
    end else if (finishing) begin
      state_nxt = IDLE;
    end else begin
      if (tick) begin
        left_nxt = left_dec;
        unique case (state)
          ACCEL, CRUISE: begin
            // Ramp length counting this pulse as an accel step.
            ramp_cand = (state == ACCEL) ? ramp_cnt + STEPS_W'(1) : ramp_cnt;
            if (left_dec <= ramp_cand) begin
              // The pulse that starts the ramp-down already takes the first
              // lengthened period, so the decel ramp mirrors the accel ramp.
              state_nxt  = DECEL;
              period_nxt = period_up;
            end else if (state == ACCEL) begin
              period_nxt = period_dn;
              ramp_nxt   = ramp_cand;
              if (period_dn == P_MIN) begin
                state_nxt = CRUISE;
              end
            end
          end
          DECEL: period_nxt = period_up;
          default: ;
        endcase
      end

      if (abort && (state == ACCEL || state == CRUISE)) begin
        state_nxt = DECEL;
        if (left_nxt > ramp_nxt) begin
          left_nxt = ramp_nxt;
        end
      end
    end
  end

`ifdef STEP_POSITION_EN
  // tick lands on the same edge as the rotate_pulse rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= '0;
    end else if (pos_clr) begin
      position <= '0;
    end else if (tick) begin
      position <= direction ? position + 32'sd1 : position - 32'sd1;
    end
  end
`endif

endmodule

// File: tb/tb_step_ramp_gen.sv
// tb/tb_step_ramp_gen.sv - directed self-checking bench for step_ramp_gen
module tb_step_ramp_gen;

  localparam int SW   = 24;
  localparam int MAXP = 100;
  localparam int MINP = 20;
  localparam int STPP = 10;
  localparam int PULW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] cmd_steps = '0;
  logic          cmd_ready, rotate_pulse, direction, busy, done;
  logic [SW-1:0] steps_left;
`ifdef STEP_POSITION_EN
  logic               pos_clr = 1'b0;
  logic signed [31:0] position;
`endif

  step_ramp_gen #(
    .PERIOD_W  (24),
    .MAX_PERIOD(MAXP),
    .MIN_PERIOD(MINP),
    .ACCEL_STEP(STPP),
    .PULSE_W   (PULW),
    .STEPS_W   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_steps   (cmd_steps),
    .cmd_dir     (cmd_dir),
    .abort       (abort),
    .rotate_pulse(rotate_pulse),
    .direction   (direction),
    .busy        (busy),
    .done        (done),
    .steps_left  (steps_left)
`ifdef STEP_POSITION_EN
    ,
    .pos_clr     (pos_clr),
    .position    (position)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int iv[0:63];

  typedef struct {
    int steps;
    bit dir;
    int abort_at;
    int exp_pulses;
    bit exp_cruise;
  } move_t;

  move_t moves[5];
  int    tri_iv[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_move(input int steps, input bit dir, input int abort_at,
                          output int np, output int nd, output int dir_bad,
                          output int timed_out, output int cruise_seen);
    int  t_last;
    bit  prev;
    bit  finished;
    np = 0; nd = 0; dir_bad = 0; cruise_seen = 0; finished = 0;
    @(negedge clk);
    cmd_steps = SW'(steps);
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t_last = cyc;
    check("accept_steps_left", 64'(steps_left), 64'(steps));
    check("accept_busy", 64'(busy), 64'(steps != 0));
    check("accept_ready_low_or_done", 64'(cmd_ready), 64'(0));
    prev = 1'b0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      if (c > 0) @(negedge clk);
      if (rotate_pulse && !prev) begin
        np++;
        if (np < 64) iv[np] = cyc - t_last;
        if (cyc - t_last == MINP) cruise_seen = 1;
        t_last = cyc;
        if (np == abort_at) abort = 1'b1;
      end
      prev = rotate_pulse;
      if (direction !== dir) dir_bad++;
      if (done) begin
        nd++;
        finished = 1;
      end
    end
    timed_out = finished ? 0 : 1;
    abort = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
      if (rotate_pulse && !prev) np++;
      prev = rotate_pulse;
    end
  endtask

  initial begin
    int np, nd, db, to, cs, rises;
    moves[0] = '{40, 1'b1, 0, 40, 1'b1};
    moves[1] = '{6, 1'b0, 0, 6, 1'b0};
    moves[2] = '{1, 1'b1, 0, 1, 1'b0};
    moves[3] = '{1000, 1'b1, 50, 58, 1'b1};
    moves[4] = '{0, 1'b1, 0, 0, 1'b0};
    tri_iv   = '{100, 90, 80, 90, 100, 100};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pulse", 64'(rotate_pulse), 64'(0));
    check("rst_direction", 64'(direction), 64'(0));
    check("rst_steps_left", 64'(steps_left), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(cmd_ready), 64'(1));

    // Table-driven moves
    for (int i = 0; i < 5; i++) begin
      run_move(moves[i].steps, moves[i].dir, moves[i].abort_at, np, nd, db, to, cs);
      check($sformatf("move%0d_timeout", i), 64'(to), 64'(0));
      check($sformatf("move%0d_pulses", i), 64'(np), 64'(moves[i].exp_pulses));
      check($sformatf("move%0d_done_count", i), 64'(nd), 64'(1));
      check($sformatf("move%0d_dir_stable", i), 64'(db), 64'(0));
      check($sformatf("move%0d_cruise", i), 64'(cs), 64'(moves[i].exp_cruise));
      if (i == 0) begin
        for (int k = 1; k <= 40; k++) begin
          int e;
          e = (k <= 8) ? 110 - 10 * k : (k <= 32) ? 20 : 10 * k - 300;
          check($sformatf("trap_interval_%0d", k), 64'(iv[k]), 64'(e));
        end
      end else if (i == 1) begin
        for (int k = 1; k <= 6; k++)
          check($sformatf("tri_interval_%0d", k), 64'(iv[k]), 64'(tri_iv[k-1]));
      end else if (i == 3) begin
        check("abort_interval_51", 64'(iv[51]), 64'(20));
        check("abort_interval_52", 64'(iv[52]), 64'(30));
        check("abort_interval_58", 64'(iv[58]), 64'(90));
      end
    end

    // Command offered while busy is refused
    @(negedge clk);
    cmd_steps = SW'(6); cmd_dir = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    cmd_steps = SW'(99); cmd_valid = 1'b1;
    @(negedge clk);
    check("busy_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_steps_left_kept", 64'(steps_left), 64'(6));
    nd = 0;
    for (int c = 0; c < 5000 && nd == 0; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("busy_move_done", 64'(nd), 64'(1));
    @(negedge clk);

    // Reset in the middle of a move, while pulse 10 is high
    cmd_steps = SW'(100); cmd_dir = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rises = 0;
    for (int c = 0; c < 5000 && rises < 10; c++) begin
      @(negedge clk);
      if (rotate_pulse && rises == 0) rises = 1;
      else if (rotate_pulse && iv[0] == 0) rises++;
      iv[0] = rotate_pulse ? 1 : 0;
    end
    check("midmove_pulse_high", 64'(rotate_pulse), 64'(1));
    check("midmove_steps_left", 64'(steps_left), 64'(90));
    rst_n = 1'b0;
    #1;
    check("midrst_pulse", 64'(rotate_pulse), 64'(0));
    check("midrst_direction", 64'(direction), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_steps_left", 64'(steps_left), 64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef STEP_POSITION_EN
    check("pos_after_reset", 64'(position), 64'(0));
    run_move(5, 1'b1, 0, np, nd, db, to, cs);
    run_move(3, 1'b0, 0, np, nd, db, to, cs);
    check("pos_net", 64'(position), 64'(2));
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    check("pos_cleared", 64'(position), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
